// File: rtl/non_pipeline.sv
// Multi-cycle, non-pipelined evaluator of result = a*b*c + d (unsigned, full precision).
// One computation in flight at a time: operands are captured on the start edge, then
// the two products and the final sum are formed in three successive states.
module non_pipeline #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  output logic                 busy,
  output logic                 done,
  output logic [3*WIDTH-1:0]   result
);

  typedef enum logic [1:0] {StIdle, StMulAb, StMulC, StAddD} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     c_q, c_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic [2*WIDTH-1:0]   p1_q, p1_d;
  logic [3*WIDTH-1:0]   p2_q, p2_d;
  logic [3*WIDTH-1:0]   result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state and datapath: each state performs exactly one arithmetic step.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = c;
          d_d     = d;
          busy_d  = 1'b1;
          state_d = StMulAb;
        end
      end
      StMulAb: begin
        // Zero-extend so the product is formed at full 2*WIDTH precision.
        p1_d    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        state_d = StMulC;
      end
      StMulC: begin
        p2_d    = {{WIDTH{1'b0}}, p1_q} * {{(2*WIDTH){1'b0}}, c_q};
        state_d = StAddD;
      end
      StAddD: begin
        // Max value (2^W-1)^3 + (2^W-1) still fits in 3*WIDTH bits.
        result_d = p2_q + {{(2*WIDTH){1'b0}}, d_q};
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_non_pipeline.sv
// Scoreboard bench for non_pipeline: the driver pushes a*b*c+d (plain arithmetic) for
// every accepted request, and a separate monitor pops and compares on each done pulse.
module tb_non_pipeline;

  localparam int unsigned WIDTH = 8;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [WIDTH-1:0]     a, b, c, d;
  logic                 busy;
  logic                 done;
  logic [3*WIDTH-1:0]   result;

  int checks   = 0;
  int failures = 0;
  longint unsigned exp_q[$];
  longint unsigned last_res = 0;

  non_pipeline #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint unsigned model(longint unsigned x, longint unsigned y,
                                            longint unsigned z, longint unsigned w);
    return x * y * z + w;
  endfunction

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: got result %0d expected no done pulse", result);
        end else begin
          longint unsigned e;
          e = exp_q.pop_front();
          if (64'(result) != e) begin
            failures++;
            $display("FAIL result: got %0d expected %0d at %0t", result, e, $time);
          end
        end
        check("busy_with_done", 64'(busy), 0);
      end
    end
  end

  // One full transaction with cycle-exact busy/done checks; junk=1 scrambles inputs while busy.
  task automatic run_op(logic [WIDTH-1:0] xa, logic [WIDTH-1:0] xb, logic [WIDTH-1:0] xc,
                        logic [WIDTH-1:0] xd, bit junk);
    longint unsigned e;
    @(negedge clk);
    check("idle_busy", 64'(busy), 0);
    check("idle_done", 64'(done), 0);
    check("idle_hold", 64'(result), last_res);
    a = xa; b = xb; c = xc; d = xd; start = 1'b1;
    e = model(64'(xa), 64'(xb), 64'(xc), 64'(xd));
    exp_q.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_high", 64'(busy), 1);
      check("done_low", 64'(done), 0);
      start = 1'b0;
      if (junk) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        c = WIDTH'($urandom); d = WIDTH'($urandom);
        start = 1'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("end_busy", 64'(busy), 0);
    check("end_done", 64'(done), 1);
    last_res = e;
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return '0;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    #1 reset = 1'b1;
    #12;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_result", 64'(result), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic, back-to-back, and maximum-operand cases.
    run_op(1, 2, 3, 4, 0);
    check("basic_10", 64'(result), 10);
    run_op(2, 3, 4, 5, 0);
    check("b2b_29", 64'(result), 29);
    run_op(3, 4, 5, 6, 0);
    check("b2b_66", 64'(result), 66);
    run_op(255, 255, 255, 255, 0);
    check("max_val", 64'(result), 16581630);

    // Start held high with operands changed while busy.
    @(negedge clk);
    check("hold_pre_busy", 64'(busy), 0);
    a = 1; b = 2; c = 3; d = 4; start = 1'b1;
    exp_q.push_back(10);
    @(negedge clk);
    a = 9; b = 9; c = 9; d = 9;
    check("hold_busy1", 64'(busy), 1);
    repeat (2) begin
      @(negedge clk);
      check("hold_busy", 64'(busy), 1);
    end
    @(negedge clk);
    check("hold_done", 64'(done), 1);
    check("hold_idle", 64'(busy), 0);
    check("hold_result", 64'(result), 10);
    exp_q.push_back(738);
    @(negedge clk);
    check("hold_resample", 64'(busy), 1);
    check("hold_done_off", 64'(done), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("hold_second_done", 64'(done), 1);
    check("hold_second_res", 64'(result), 738);
    last_res = 738;

    // Reset during MUL_C aborts the computation immediately.
    @(negedge clk);
    a = 7; b = 8; c = 9; d = 10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 0);
    check("abort_result", 64'(result), 0);
    check("abort_done", 64'(done), 0);
    last_res = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 0);
    end
    run_op(2, 3, 4, 5, 0);
    check("after_rst_29", 64'(result), 29);

    // Randomized traffic with idle gaps and scrambled inputs while busy.
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        check("gap_done", 64'(done), 0);
      end
      run_op(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1);
    end

    // Drain: all expectations must have been consumed within a bounded time.
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/non_pipeline.md
NON_PIPELINE -- requirements
Module: non_pipeline

Interface
REQ-001 Parameter WIDTH, default 8: width of each operand a, b, c, d.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: request to begin a computation; sampled on rising clk edges.
REQ-005 Port a, input, WIDTH: unsigned operand a.
REQ-006 Port b, input, WIDTH: unsigned operand b.
REQ-007 Port c, input, WIDTH: unsigned operand c.
REQ-008 Port d, input, WIDTH: unsigned operand d.
REQ-009 Port busy, output, 1: high while a computation is in progress.
REQ-010 Port done, output, 1: one-cycle pulse when result is updated.
REQ-011 Port result, output, 3*WIDTH: registered unsigned a*b*c+d of the last completed computation.

Function
REQ-012 The block SHALL compute result = a*b*c + d, unsigned, without pipelining: at most one computation in flight.
REQ-013 Full-precision arithmetic SHALL be used with no truncation or wrap: a*b is 2*WIDTH bits, (a*b)*c is 3*WIDTH bits, and +d fits in 3*WIDTH bits. For WIDTH=8 the maximum is 16581630.
REQ-014 The FSM SHALL have four states: IDLE, MUL_AB, MUL_C, ADD_D.
REQ-015 IDLE: on an edge with start=1, the block SHALL register a, b, c and d into internal operand registers, set busy<=1, and go to MUL_AB; with start=0 it SHALL stay in IDLE.
REQ-016 MUL_AB: p1 <= a_r*b_r (2*WIDTH bits); go to MUL_C.
REQ-017 MUL_C: p2 <= p1*c_r (3*WIDTH bits); go to ADD_D.
REQ-018 ADD_D: result <= p2 + d_r; done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
REQ-019 Latency SHALL be fixed: busy is high for exactly 3 cycles, and result and done are valid starting on the 4th rising edge after the start-sampling edge is counted as edge 0 (i.e., at edge 3).
REQ-020 Operands SHALL be captured only at the start-sampling edge; changes to a, b, c or d while busy SHALL NOT affect the result.
REQ-021 start SHALL be ignored while busy=1; no queuing, no abort.
REQ-022 If start is still high on the edge at which the FSM returns to IDLE, it SHALL NOT be sampled on that edge; it SHALL be sampled on the next edge, starting a new computation with the operands present then.
REQ-023 result SHALL hold its value between computations and change only in ADD_D.
REQ-024 done and busy SHALL never be high in the same cycle.

Reset
REQ-025 While reset=1, the block SHALL immediately, without waiting for clk, set state=IDLE, busy=0, done=0, result=0, and clear all internal operand and product registers.
REQ-026 Reset asserted mid-computation SHALL abort the computation; no done pulse SHALL follow, and result SHALL read 0.
REQ-027 After reset is released, the first rising edge with start=1 SHALL begin a normal computation.

Verification
REQ-028 Load a=1, b=2, c=3, d=4 and pulse start until busy rises -> busy high for 3 cycles, done pulse, result=10.
REQ-029 Run back-to-back 2,3,4,5 and then 3,4,5,6, waiting for busy=0 between them -> results 29 then 66, each with exactly one done pulse.
REQ-030 Load a=b=c=d=255 -> result=16581630, with no overflow.
REQ-031 Start with 1,2,3,4, then change the operands to 9,9,9,9 and hold start high while busy -> result=10, and the second request is sampled only after returning to IDLE.
REQ-032 Assert reset during MUL_C -> busy=0 and result=0 immediately, no done pulse, and a fresh start with 2,3,4,5 then gives result=29.
